// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Fetch program-counter register and redirect controller.
//  - Steps the PC by PC_STEP on every accepted, unstalled fetch.
//  - A taken branch/jump loads the resolved target and raises a registered
//    Flush for FLUSH_CYCLES cycles so IF/ID can squash wrong-path fetches.
//  - HALT on the correct path freezes the PC until reset.
// Optional build macro: PC_ALIGN_CHK_EN
//  - Defined: a redirect to an odd target raises the sticky Err, enters
//    HALTED and leaves the PC untouched.
//  - Undefined: targets load as-is and Err stays 0.
module pc_redirect_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned PC_STEP      = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BrchOrJmpSig,
  input  logic [15:0] BrchTarget,
  input  logic        Stall,
  input  logic        FetchReady,
  input  logic        Halt,
  output logic [15:0] PC,
  output logic [15:0] PCInc,
  output logic        Flush,
  output logic        Halted,
  output logic        Err
);

  // Increment as a 16-bit constant so the add wraps modulo 2^16.
  localparam logic [15:0] PC_STEP_W = 16'(PC_STEP);

  // Clamp the flush length into the 1..7 range the 3-bit counter can express.
  localparam int unsigned FLUSH_LEN =
    (FLUSH_CYCLES < 1) ? 1 : ((FLUSH_CYCLES > 7) ? 7 : FLUSH_CYCLES);

  // The counter counts down to zero; a reload value of FLUSH_LEN-1 yields
  // exactly FLUSH_LEN cycles of Flush.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Sequential next PC, wrapping modulo 2^16.
  function automatic logic [15:0] pc_step_fn(input logic [15:0] pc_in);
    return pc_in + PC_STEP_W;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_s;
  logic [15:0] pc_r;
  logic [15:0] pc_s;
  logic        flush_r;
  logic        halted_r;
  logic        err_r;
  logic        err_s;
  logic        misalign_s;
  logic        fetch_adv_s;

`ifdef PC_ALIGN_CHK_EN
  // An odd redirect target cannot be fetched; flag it instead of loading it.
  assign misalign_s = BrchTarget[0];
`else
  // Without the alignment check every target is accepted unchanged.
  assign misalign_s = 1'b0;
`endif

  // A fetch advances only when memory took the PC and the pipeline is not held.
  assign fetch_adv_s = (!Stall) && FetchReady;

  // Next-state, next-PC and flush-counter decision with fixed priority:
  // redirect, then (RUN only) halt, then sequential step, else hold.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pc_s    = pc_r;
    err_s   = err_r;
    case (state_r)
      ST_RUN, ST_FLUSH: begin
        if (BrchOrJmpSig) begin
          if (misalign_s) begin
            // Bad target: stop the core, keep the old PC, drop the flush.
            state_s = ST_HALTED;
            err_s   = 1'b1;
            cnt_s   = 3'd0;
          end else begin
            // Redirect wins over stall, memory wait and halt; a redirect
            // inside FLUSH restarts the count so Flush stays high.
            pc_s    = BrchTarget;
            state_s = ST_FLUSH;
            cnt_s   = CNT_LOAD;
          end
        end else if ((state_r == ST_RUN) && Halt) begin
          // HALT is honoured only on the correct path (RUN); PC holds.
          state_s = ST_HALTED;
        end else begin
          if (fetch_adv_s) begin
            pc_s = pc_step_fn(pc_r);
          end else begin
            pc_s = pc_r;
          end
          if (state_r == ST_FLUSH) begin
            // Wrong-path HALT is ignored here; only the counter matters.
            if (cnt_r == 3'd0) begin
              state_s = ST_RUN;
            end else begin
              cnt_s = cnt_r - 3'd1;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        // Frozen until reset; every input is ignored.
        state_s = ST_HALTED;
      end
      default: begin
        // Unreachable encoding: fall back to a safe running state.
        state_s = ST_RUN;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // State, PC, counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_RUN;
      cnt_r    <= 3'd0;
      pc_r     <= RESET_PC;
      flush_r  <= 1'b0;
      halted_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pc_r     <= pc_s;
      flush_r  <= (state_s == ST_FLUSH);
      halted_r <= (state_s == ST_HALTED);
      err_r    <= err_s;
    end
  end

  assign PC     = pc_r;
  assign PCInc  = pc_step_fn(pc_r);
  assign Flush  = flush_r;
  assign Halted = halted_r;
  assign Err    = err_r;

endmodule
